sparse_act_feeder: RTL and testbench
====================================

Name: sparse_act_feeder

Overview:
- Upstream activation stage for the sparse MAC row.
- Accepts one dense activation group per handshake. Each group holds GRP unsigned activations.
- Strips zero activations and streams the non-zero ones two per beat, each with its in-group index. Output format is in_activation_flat / act_index_flat, ready to drive the MAC row.
- Uses valid/ready handshakes on both sides and one group of internal buffering, so back-to-back groups flow without bubbles.

Parameters:
- bw, 4, activation bit width (unsigned).
- idx_bw, 2, index width; GRP = 2**idx_bw activations per group (4 by default).
- cnt_bw, 16, width of the processed-group counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  dense group present on in_act_flat.
- in_ready  out  1  feeder can accept a group this cycle.
- in_act_flat  in  GRP*bw  dense group; lane i at bits [i*bw +: bw].
- out_valid  out  1  beat present on outputs.
- out_ready  in  1  downstream accepts beat.
- out_activation_flat  out  2*bw  lane0 at [bw-1:0], lane1 at [2*bw-1:bw].
- out_act_index_flat  out  2*idx_bw  index of lane0 at [idx_bw-1:0], lane1 above.
- out_lane_valid  out  2  per-lane valid; bit0 = lane0.
- out_last  out  1  final beat of current group.
- group_count  out  cnt_bw  groups fully emitted since reset; wraps modulo 2**cnt_bw.

Behaviour:
- Reset (reset==0 at posedge):
  - state = IDLE.
  - out_valid, out_activation_flat, out_act_index_flat, out_lane_valid, out_last, group_count, and the internal mask all = 0.
  - in_ready forced 0 while reset==0. Reset mid-group discards the group; no further beats are emitted.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- State IDLE:
  - in_ready=1 and out_valid=0.
  - On input transfer: register the group and nz_mask[i] = (act[i]!=0), go to EMIT.
- State EMIT:
  - out_valid=1. Outputs are registered, so the first beat appears the cycle after the input transfer (latency 1).
  - Beat content: lane0 = lowest set bit of the remaining mask; lane1 = next lowest set bit, if any.
  - An unused lane drives activation 0, index 0, lane_valid 0.
  - out_last=1 when the remaining mask has no set bits beyond this beat's lanes.
  - On an output transfer that is not last: clear the two consumed mask bits and present the next beat the following cycle.
  - On an output transfer with last=1:
    - group_count increments.
    - If in_valid=1 in the same cycle, accept the new group (stay in EMIT) and present its first beat next cycle; no bubble.
    - Otherwise return to IDLE.
- in_ready = (state==IDLE) | (state==EMIT & out_valid & out_ready & out_last), gated by reset. This path is combinational.
- All-zero group: emit exactly one beat with out_lane_valid=00 and out_last=1, so downstream stays group-aligned.
- Beat count per group = max(1, ceil(popcount/2)). Full group (4 nonzero, GRP=4) = 2 beats.
- Index order within and across beats is strictly ascending.
- group_count wraps from all-ones to 0.
- out_valid never asserts in IDLE. in_act_flat is ignored when no input transfer occurs.

Test Plan:
- Reset hold: reset=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, group_count=0, and all outputs 0.
- Full group: in_act={lane3..0}={4,3,2,1}, out_ready=1. Required response:
  - First beat one cycle later: act {2,1}, idx {1,0}, lane_valid 11, last 0.
  - Second beat: act {4,3}, idx {3,2}, lane_valid 11, last 1.
  - group_count becomes 1.
- Sparse and odd groups, out_ready=1:
  - in_act={0,9,0,5} -> one beat: act {9,5}, idx {2,0}, lane_valid 11, last 1.
  - {7,0,0,0} -> one beat: act {0,7}, idx {0,3}, lane_valid 01, last 1.
- All-zero group: in_act=0 -> one beat with lane_valid 00, last 1; group_count increments.
- Backpressure: full group {4,3,2,1} with out_ready=0 for 5 cycles -> first beat held stable and in_ready=0 throughout. Then with out_ready=1: two beats in consecutive cycles, no data loss.
- Streaming, out_ready=1 constant: in_valid held high with groups {4,3,2,1}, {0,0,6,0}, {1,1,1,1} -> beats emitted every cycle with no bubbles (2+1+2 beats over 5 cycles); in_ready pulses on each last beat; group_count=3.

Source files
------------

// File: rtl/sparse_act_feeder.sv
// Zero-skipping activation feeder: takes one dense group per handshake and
// streams its non-zero activations two per beat, each with its in-group index.
//
// state | meaning
// IDLE  | no group held; ready for a new dense group
// EMIT  | group held; presenting beats until the last one is accepted
module sparse_act_feeder #(
   parameter int bw     = 4,
   parameter int idx_bw = 2,
   parameter int cnt_bw = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [(2**idx_bw)*bw-1:0]    in_act_flat,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2*bw-1:0]              out_activation_flat,
   output logic [2*idx_bw-1:0]          out_act_index_flat,
   output logic [1:0]                   out_lane_valid,
   output logic                         out_last,
   output logic [cnt_bw-1:0]            group_count
);

   localparam int GRP = 2**idx_bw;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t              state_q, state_d;
   logic [GRP*bw-1:0]   act_q;
   logic [GRP-1:0]      mask_q;
   logic [GRP-1:0]      rest_mask;
   logic [GRP-1:0]      in_mask;
   logic                found0, found1;
   logic [idx_bw-1:0]   idx0, idx1;
   logic                beat_last;
   logic                in_xfer, out_xfer;

   // Pick the two lowest set bits of the remaining mask; what is left decides last.
   always_comb begin
      found0    = 1'b0;
      found1    = 1'b0;
      idx0      = '0;
      idx1      = '0;
      for (int i = 0; i < GRP; i++) begin
         if (mask_q[i]) begin
            if (!found0) begin
               found0 = 1'b1;
               idx0   = idx_bw'(i);
            end else if (!found1) begin
               found1 = 1'b1;
               idx1   = idx_bw'(i);
            end
         end
      end
      rest_mask = mask_q;
      if (found0) rest_mask[idx0] = 1'b0;
      if (found1) rest_mask[idx1] = 1'b0;
      beat_last = (rest_mask == '0);
   end

   always_comb begin
      in_mask = '0;
      for (int i = 0; i < GRP; i++) begin
         in_mask[i] = (in_act_flat[i*bw +: bw] != '0);
      end
   end

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_xfer) state_d = EMIT;
         EMIT: if (out_xfer && beat_last && !in_xfer) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid           = (state_q == EMIT);
      in_ready            = reset & ((state_q == IDLE) |
                                     ((state_q == EMIT) & out_ready & beat_last));
      out_last            = out_valid & beat_last;
      out_lane_valid      = out_valid ? {found1, found0} : 2'b00;
      out_activation_flat = '0;
      out_act_index_flat  = '0;
      if (out_valid && found0) begin
         out_activation_flat[bw-1:0]     = act_q[int'(idx0)*bw +: bw];
         out_act_index_flat[idx_bw-1:0]  = idx0;
      end
      if (out_valid && found1) begin
         out_activation_flat[2*bw-1:bw]        = act_q[int'(idx1)*bw +: bw];
         out_act_index_flat[2*idx_bw-1:idx_bw] = idx1;
      end
   end

   // A last-beat transfer leaves rest_mask empty, so the mask self-clears on return to IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         act_q       <= '0;
         mask_q      <= '0;
         group_count <= '0;
      end else begin
         if (in_xfer) begin
            act_q  <= in_act_flat;
            mask_q <= in_mask;
         end else if (out_xfer) begin
            mask_q <= rest_mask;
         end
         if (out_xfer && beat_last) group_count <= group_count + cnt_bw'(1);
      end
   end

endmodule

// File: tb/tb_sparse_act_feeder.sv
// Directed bench for sparse_act_feeder: each task drives one scenario and
// compares beats against hand-computed values.
module tb_sparse_act_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_act_flat;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_activation_flat;
   logic [3:0]  out_act_index_flat;
   logic [1:0]  out_lane_valid;
   logic        out_last;
   logic [15:0] group_count;

   int errors = 0;
   int checks = 0;

   // {valid, last, lane_valid, idx1, idx0, act1, act0}
   logic [15:0] beat;
   assign beat = {out_valid, out_last, out_lane_valid, out_act_index_flat, out_activation_flat};

   sparse_act_feeder #(.bw(4), .idx_bw(2), .cnt_bw(16)) dut (
      .clk                 (clk),
      .reset               (reset),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_act_flat         (in_act_flat),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_activation_flat (out_activation_flat),
      .out_act_index_flat  (out_act_index_flat),
      .out_lane_valid      (out_lane_valid),
      .out_last            (out_last),
      .group_count         (group_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      in_valid    = 1'b1;
      in_act_flat = 16'h4321;
      out_ready   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
         end
         checks++;
         if ({beat, group_count} !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: beat=%h count=%0d want all 0", beat, group_count);
         end
      end
      reset    = 1'b1;
      in_valid = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_full_group();
      in_act_flat = {4'd4, 4'd3, 4'd2, 4'd1};
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (beat !== {1'b1, 1'b0, 2'b11, 2'd1, 2'd0, 4'd2, 4'd1}) begin
         errors++; $display("FAIL full_beat0: got %h want %h", beat, {1'b1, 1'b0, 2'b11, 2'd1, 2'd0, 4'd2, 4'd1});
      end
      step();
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b11, 2'd3, 2'd2, 4'd4, 4'd3}) begin
         errors++; $display("FAIL full_beat1: got %h want %h", beat, {1'b1, 1'b1, 2'b11, 2'd3, 2'd2, 4'd4, 4'd3});
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || group_count !== 16'd1) begin
         errors++; $display("FAIL full_done: out_valid=%b count=%0d want 0/1", out_valid, group_count);
      end
   endtask

   task automatic test_sparse();
      in_act_flat = {4'd0, 4'd9, 4'd0, 4'd5};
      in_valid    = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b11, 2'd2, 2'd0, 4'd9, 4'd5}) begin
         errors++; $display("FAIL sparse_two: got %h want %h", beat, {1'b1, 1'b1, 2'b11, 2'd2, 2'd0, 4'd9, 4'd5});
      end
      step();
      in_act_flat = {4'd7, 4'd0, 4'd0, 4'd0};
      in_valid    = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b01, 2'd0, 2'd3, 4'd0, 4'd7}) begin
         errors++; $display("FAIL sparse_one: got %h want %h", beat, {1'b1, 1'b1, 2'b01, 2'd0, 2'd3, 4'd0, 4'd7});
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || group_count !== 16'd3) begin
         errors++; $display("FAIL sparse_done: out_valid=%b count=%0d want 0/3", out_valid, group_count);
      end
   endtask

   task automatic test_all_zero();
      in_act_flat = 16'h0000;
      in_valid    = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b00, 4'h0, 8'h00}) begin
         errors++; $display("FAIL zero_beat: got %h want %h", beat, {1'b1, 1'b1, 2'b00, 4'h0, 8'h00});
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || group_count !== 16'd4) begin
         errors++; $display("FAIL zero_done: out_valid=%b count=%0d want 0/4", out_valid, group_count);
      end
   endtask

   task automatic test_backpressure();
      in_act_flat = {4'd4, 4'd3, 4'd2, 4'd1};
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      step();
      in_valid    = 1'b0;
      in_act_flat = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (beat !== {1'b1, 1'b0, 2'b11, 2'd1, 2'd0, 4'd2, 4'd1} || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold cycle %0d: beat=%h in_ready=%b want %h/0", k, beat, in_ready,
                               {1'b1, 1'b0, 2'b11, 2'd1, 2'd0, 4'd2, 4'd1});
         end
         step();
      end
      out_ready = 1'b1;
      checks++;
      if (beat !== {1'b1, 1'b0, 2'b11, 2'd1, 2'd0, 4'd2, 4'd1}) begin
         errors++; $display("FAIL bp_release0: got %h", beat);
      end
      step();
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b11, 2'd3, 2'd2, 4'd4, 4'd3} || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release1: beat=%h in_ready=%b want %h/1", beat, in_ready,
                            {1'b1, 1'b1, 2'b11, 2'd3, 2'd2, 4'd4, 4'd3});
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || group_count !== 16'd5) begin
         errors++; $display("FAIL bp_done: out_valid=%b count=%0d want 0/5", out_valid, group_count);
      end
   endtask

   task automatic test_back_to_back();
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_act_flat = {4'd4, 4'd3, 4'd2, 4'd1};
      step();
      in_act_flat = {4'd0, 4'd0, 4'd6, 4'd0};
      checks++;
      if (beat !== {1'b1, 1'b0, 2'b11, 2'd1, 2'd0, 4'd2, 4'd1} || in_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_g1a: beat=%h in_ready=%b", beat, in_ready);
      end
      step();
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b11, 2'd3, 2'd2, 4'd4, 4'd3} || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_g1b: beat=%h in_ready=%b", beat, in_ready);
      end
      step();
      in_act_flat = {4'd1, 4'd1, 4'd1, 4'd1};
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b01, 2'd0, 2'd1, 4'd0, 4'd6} || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_g2: beat=%h in_ready=%b", beat, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (beat !== {1'b1, 1'b0, 2'b11, 2'd1, 2'd0, 4'd1, 4'd1} || in_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_g3a: beat=%h in_ready=%b", beat, in_ready);
      end
      step();
      checks++;
      if (beat !== {1'b1, 1'b1, 2'b11, 2'd3, 2'd2, 4'd1, 4'd1} || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_g3b: beat=%h in_ready=%b", beat, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || group_count !== 16'd8) begin
         errors++; $display("FAIL b2b_done: out_valid=%b count=%0d want 0/8", out_valid, group_count);
      end
   endtask

   task automatic test_mid_reset();
      in_act_flat = {4'd4, 4'd3, 4'd2, 4'd1};
      in_valid    = 1'b1;
      step();
      in_valid = 1'b0;
      reset    = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || group_count !== 16'd0) begin
         errors++; $display("FAIL mid_reset: out_valid=%b in_ready=%b count=%0d want 0/0/0",
                            out_valid, in_ready, group_count);
      end
      reset = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b0;
      in_act_flat = '0;
      out_ready   = 1'b0;
      test_reset();
      test_full_group();
      test_sparse();
      test_all_zero();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
